regfile_decode_stage: RTL and testbench
=======================================

# regfile_decode_stage

Decode-stage register file plus ID/EX pipeline latch for the pipelined RV32I/RV64I core. Holds x1–x31, serves two combinational read ports (Rd1/Rd2) to decode, accepts one writeback per cycle, and registers decode operands into the execute stage under stall/flush control. It also flags load-use hazards against the instruction currently in execute. Rd1 is the signal the lockstep trace benches compare every cycle, so its per-cycle value is architecturally pinned.

## Interface
Parameters:
- XLEN, 32, register width (32 or 64).
- NREG, 32, architectural register count; address width is log2(NREG).

Ports:
- clk  in  1  core clock, all state updates on rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- Rs1D, Rs2D  in  5  decode source addresses.
- RdD  in  5  decode destination address.
- ValidD  in  1  decode slot holds a real instruction.
- MemReadD  in  1  decode instruction is a load.
- WE3  in  1  writeback enable.
- A3  in  5  writeback address.
- WD3  in  XLEN  writeback data.
- StallD  in  1  hold ID/EX latch.
- FlushE  in  1  insert bubble into ID/EX latch.
- Rd1, Rd2  out  XLEN  combinational read data for Rs1D/Rs2D.
- Rd1E, Rd2E  out  XLEN  latched operands.
- Rs1E, Rs2E, RdE  out  5  latched addresses (for forwarding unit).
- ValidE, MemReadE  out  1  latched control.
- LoadUseHazard  out  1  combinational hazard flag to the hazard unit.

## Operation
- Storage: x1–x31 flops; x0 not stored, reads of address 0 return 0, writes to A3=0 ignored.
- Write: on rising clk with WE3=1 and A3≠0, reg[A3] ← WD3.
- Read: Rd1 = (Rs1D==0) ? 0 : reg[Rs1D]; Rd2 likewise. Bypass behaviour per Configuration.
- ID/EX latch priority on rising clk: FlushE → all latch outputs 0 (bubble); else StallD → hold; else capture {Rd1, Rd2, Rs1D, Rs2D, RdD, ValidD, MemReadD}.
- FlushE and StallD both high: flush wins.
- LoadUseHazard = ValidE & MemReadE & (RdE≠0) & ValidD & ((RdE==Rs1D) | (RdE==Rs2D)). Block does not self-stall; hazard unit drives StallD/FlushE from it.
- Captured Rd1E/Rd2E reflect read-port values at the capture edge (including bypass when enabled).

## Timing
- Reset (async, any time incl. mid-write): all 31 registers 0; Rd1E, Rd2E, Rs1E, Rs2E, RdE, ValidE, MemReadE = 0; Rd1/Rd2 = 0 as a consequence.
- Reset deassertion: first capture/write on next rising edge after reset low.
- Read latency: 0 cycles (combinational). Latch latency: 1 cycle.
- Write visibility: without bypass, value written at edge N is readable after edge N; with bypass, readable in the same cycle WE3 is presented.
- WE3 during reset: ignored.
- Stall held for k cycles: latch outputs constant for k cycles; register file writes continue.

## Configuration
- REGFILE_BYPASS_EN defined: if WE3=1, A3≠0, A3==Rs1D then Rd1=WD3 (same for Rd2/Rs2D); decode sees writeback in the same cycle. Required for the pipelined expected traces.
- Undefined: no bypass; Rd1/Rd2 show pre-write contents during the writeback cycle. Used with the unpipelined expected traces.

## Test plan
- Reset mid-operation: write x5=0xDEAD, assert reset asynchronously between edges → Rd1 (Rs1D=5)=0 immediately, all latch outputs 0.
- x0 protection: WE3=1, A3=0, WD3=0xFFFF_FFFF → Rs1D=0 gives Rd1=0 next cycle and same cycle.
- Bypass: WE3=1, A3=7, WD3=0x1234, Rs1D=7 same cycle → Rd1=0x1234 with REGFILE_BYPASS_EN, old value (0) without; both give 0x1234 next cycle.
- Stall/flush: capture Rd1E=0xA, then StallD=1 for 3 cycles with changing Rs1D → Rd1E stays 0xA; assert StallD and FlushE together → ValidE=0, Rd1E=0.
- Load-use: latch load with RdE=3, MemReadE=1, ValidE=1; decode Rs2D=3, ValidD=1 → LoadUseHazard=1; RdE=0 or ValidD=0 → 0.
- XLEN=64: write x31=0x8000_0000_0000_0001, read via Rs2D=31 → Rd2 full 64-bit value, Rd2E equal after one edge.

Source files
------------

// File: rtl/regfile_decode_stage.sv
// regfile_decode_stage
//
// Decode-stage register file (x1..x31) with the ID/EX pipeline latch for the
// pipelined RV32I/RV64I core. Two combinational read ports feed decode, one
// writeback port updates the file each cycle, and the decode operands are
// registered into execute under stall/flush control. A load-use hazard flag
// compares the instruction in execute against the one in decode.
//
// Optional feature macro:
//   REGFILE_BYPASS_EN - when defined, a writeback presented this cycle is
//                       forwarded onto Rd1/Rd2 (and so into Rd1E/Rd2E).
//                       When undefined, reads show pre-write contents.
//
// Parameters:
//   XLEN  register width (32 or 64)
//   NREG  architectural register count (address width = log2(NREG))
//
// Ports:
//   clk, reset             clock; asynchronous active-high reset
//   Rs1D, Rs2D, RdD        decode source/destination addresses
//   ValidD, MemReadD       decode slot valid / decode instruction is a load
//   WE3, A3, WD3           writeback enable, address, data
//   StallD, FlushE         hold / bubble the ID/EX latch (flush wins)
//   Rd1, Rd2               combinational read data for Rs1D/Rs2D
//   Rd1E, Rd2E             latched operands
//   Rs1E, Rs2E, RdE        latched addresses for the forwarding unit
//   ValidE, MemReadE       latched control
//   LoadUseHazard          load in execute feeds a source in decode

module regfile_decode_stage #(
    parameter  int XLEN = 32,
    parameter  int NREG = 32,
    localparam int AW   = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [AW-1:0]   Rs1D,
    input  logic [AW-1:0]   Rs2D,
    input  logic [AW-1:0]   RdD,
    input  logic            ValidD,
    input  logic            MemReadD,
    input  logic            WE3,
    input  logic [AW-1:0]   A3,
    input  logic [XLEN-1:0] WD3,
    input  logic            StallD,
    input  logic            FlushE,
    output logic [XLEN-1:0] Rd1,
    output logic [XLEN-1:0] Rd2,
    output logic [XLEN-1:0] Rd1E,
    output logic [XLEN-1:0] Rd2E,
    output logic [AW-1:0]   Rs1E,
    output logic [AW-1:0]   Rs2E,
    output logic [AW-1:0]   RdE,
    output logic            ValidE,
    output logic            MemReadE,
    output logic            LoadUseHazard
);

    // x0 is hardwired to zero, so only x1..x(NREG-1) get storage.
    logic [XLEN-1:0] regs_q [1:NREG-1];
    logic [XLEN-1:0] regs_d [1:NREG-1];

    logic [XLEN-1:0] rd1e_q, rd1e_d;
    logic [XLEN-1:0] rd2e_q, rd2e_d;
    logic [AW-1:0]   rs1e_q, rs1e_d;
    logic [AW-1:0]   rs2e_q, rs2e_d;
    logic [AW-1:0]   rde_q, rde_d;
    logic            valide_q, valide_d;
    logic            memreade_q, memreade_d;

    logic            wr_en;

    assign wr_en = WE3 && (A3 != '0);

    // Writeback into the register file.
    always_comb begin
        regs_d = regs_q;
        if (wr_en) begin
            regs_d[A3] = WD3;
        end
    end

    // Read ports. The array index is only evaluated for nonzero addresses.
    always_comb begin
        Rd1 = (Rs1D == '0) ? '0 : regs_q[Rs1D];
        Rd2 = (Rs2D == '0) ? '0 : regs_q[Rs2D];
`ifdef REGFILE_BYPASS_EN
        // wr_en already excludes x0, so a match implies a nonzero source.
        if (wr_en && (A3 == Rs1D)) begin
            Rd1 = WD3;
        end
        if (wr_en && (A3 == Rs2D)) begin
            Rd2 = WD3;
        end
`endif
    end

    // ID/EX latch next state: flush beats stall, stall beats capture.
    always_comb begin
        rd1e_d     = rd1e_q;
        rd2e_d     = rd2e_q;
        rs1e_d     = rs1e_q;
        rs2e_d     = rs2e_q;
        rde_d      = rde_q;
        valide_d   = valide_q;
        memreade_d = memreade_q;
        if (FlushE) begin
            rd1e_d     = '0;
            rd2e_d     = '0;
            rs1e_d     = '0;
            rs2e_d     = '0;
            rde_d      = '0;
            valide_d   = 1'b0;
            memreade_d = 1'b0;
        end else if (!StallD) begin
            rd1e_d     = Rd1;
            rd2e_d     = Rd2;
            rs1e_d     = Rs1D;
            rs2e_d     = Rs2D;
            rde_d      = RdD;
            valide_d   = ValidD;
            memreade_d = MemReadD;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 1; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
            rd1e_q     <= '0;
            rd2e_q     <= '0;
            rs1e_q     <= '0;
            rs2e_q     <= '0;
            rde_q      <= '0;
            valide_q   <= 1'b0;
            memreade_q <= 1'b0;
        end else begin
            regs_q     <= regs_d;
            rd1e_q     <= rd1e_d;
            rd2e_q     <= rd2e_d;
            rs1e_q     <= rs1e_d;
            rs2e_q     <= rs2e_d;
            rde_q      <= rde_d;
            valide_q   <= valide_d;
            memreade_q <= memreade_d;
        end
    end

    assign Rd1E     = rd1e_q;
    assign Rd2E     = rd2e_q;
    assign Rs1E     = rs1e_q;
    assign Rs2E     = rs2e_q;
    assign RdE      = rde_q;
    assign ValidE   = valide_q;
    assign MemReadE = memreade_q;

    // A load in execute whose destination is a live source of decode. x0 as
    // destination never creates a dependency.
    assign LoadUseHazard = valide_q && memreade_q && (rde_q != '0) && ValidD &&
                           ((rde_q == Rs1D) || (rde_q == Rs2D));

endmodule

// File: tb/tb_regfile_decode_stage.sv
module tb_regfile_decode_stage;

    localparam int XLEN = 32;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // 32-bit DUT signals
    logic [4:0]      Rs1D, Rs2D, RdD, A3;
    logic            ValidD, MemReadD, WE3, StallD, FlushE;
    logic [XLEN-1:0] WD3;
    logic [XLEN-1:0] Rd1, Rd2, Rd1E, Rd2E;
    logic [4:0]      Rs1E, Rs2E, RdE;
    logic            ValidE, MemReadE, LoadUseHazard;

    // 64-bit DUT signals
    logic [4:0]  w_rs1, w_rs2, w_rdd, w_a3;
    logic        w_vd, w_mrd, w_we, w_st, w_fl;
    logic [63:0] w_wd, w_rd1, w_rd2, w_rd1e, w_rd2e;
    logic [4:0]  w_rs1e, w_rs2e, w_rde;
    logic        w_ve, w_mre, w_luh;

    regfile_decode_stage #(.XLEN(XLEN), .NREG(32)) u_dut (
        .clk(clk), .reset(reset),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD), .ValidD(ValidD), .MemReadD(MemReadD),
        .WE3(WE3), .A3(A3), .WD3(WD3), .StallD(StallD), .FlushE(FlushE),
        .Rd1(Rd1), .Rd2(Rd2), .Rd1E(Rd1E), .Rd2E(Rd2E),
        .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .ValidE(ValidE), .MemReadE(MemReadE),
        .LoadUseHazard(LoadUseHazard)
    );

    regfile_decode_stage #(.XLEN(64), .NREG(32)) u_dut64 (
        .clk(clk), .reset(reset),
        .Rs1D(w_rs1), .Rs2D(w_rs2), .RdD(w_rdd), .ValidD(w_vd), .MemReadD(w_mrd),
        .WE3(w_we), .A3(w_a3), .WD3(w_wd), .StallD(w_st), .FlushE(w_fl),
        .Rd1(w_rd1), .Rd2(w_rd2), .Rd1E(w_rd1e), .Rd2E(w_rd2e),
        .Rs1E(w_rs1e), .Rs2E(w_rs2e), .RdE(w_rde), .ValidE(w_ve), .MemReadE(w_mre),
        .LoadUseHazard(w_luh)
    );

    typedef struct packed {
        logic [XLEN-1:0] rd1;
        logic [XLEN-1:0] rd2;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic            v;
        logic            mr;
    } lat_t;

    logic [XLEN-1:0] m_regs [32];
    lat_t            m_lat;
    lat_t            exp_q [$];

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_assert++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [XLEN-1:0] m_read(input logic [4:0] a);
        if (a == 5'd0) return '0;
        if (BYP && WE3 && (A3 != 5'd0) && (A3 == a)) return WD3;
        return m_regs[a];
    endfunction

    task automatic check_lat(input lat_t e, input string pfx);
        chk({pfx, "_Rd1E"},     Rd1E,     e.rd1);
        chk({pfx, "_Rd2E"},     Rd2E,     e.rd2);
        chk({pfx, "_Rs1E"},     Rs1E,     e.rs1);
        chk({pfx, "_Rs2E"},     Rs2E,     e.rs2);
        chk({pfx, "_RdE"},      RdE,      e.rd);
        chk({pfx, "_ValidE"},   ValidE,   e.v);
        chk({pfx, "_MemReadE"}, MemReadE, e.mr);
    endtask

    task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                         input logic v, input logic mr, input logic we,
                         input logic [4:0] a3, input logic [XLEN-1:0] wd,
                         input logic st, input logic fl);
        Rs1D = rs1; Rs2D = rs2; RdD = rd; ValidD = v; MemReadD = mr;
        WE3 = we; A3 = a3; WD3 = wd; StallD = st; FlushE = fl;
    endtask

    // One clock of operation with inputs already driven: check combinational
    // outputs against the model, queue the expected latch contents, clock,
    // then retire the queue head against the latch outputs.
    task automatic cycle();
        lat_t            e;
        logic [XLEN-1:0] r1, r2;
        logic            haz;
        #3;
        r1  = m_read(Rs1D);
        r2  = m_read(Rs2D);
        haz = m_lat.v && m_lat.mr && (m_lat.rd != 5'd0) && ValidD &&
              ((m_lat.rd == Rs1D) || (m_lat.rd == Rs2D));
        chk("Rd1", Rd1, r1);
        chk("Rd2", Rd2, r2);
        chk("LoadUseHazard", LoadUseHazard, haz);
        if (FlushE)      e = '0;
        else if (StallD) e = m_lat;
        else             e = '{rd1: r1, rd2: r2, rs1: Rs1D, rs2: Rs2D, rd: RdD, v: ValidD, mr: MemReadD};
        exp_q.push_back(e);
        @(posedge clk);
        if (WE3 && (A3 != 5'd0)) m_regs[A3] = WD3;
        #1;
        if (exp_q.size() == 0) begin
            chk("scoreboard_empty", 1, 0);
        end else begin
            m_lat = exp_q.pop_front();
            check_lat(m_lat, "lat");
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
        m_lat = '0;
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, '0, 0, 0);
        w_rs1 = 0; w_rs2 = 0; w_rdd = 0; w_a3 = 0; w_vd = 0; w_mrd = 0;
        w_we = 0; w_st = 0; w_fl = 0; w_wd = '0;

        // Reset state
        @(posedge clk); #1;
        drive(3, 4, 5, 1, 1, 1, 3, 32'h5555, 0, 0);  // WE3 during reset is ignored
        @(posedge clk); #1;
        check_lat('0, "rst");
        chk("rst_Rd1", Rd1, BYP ? 32'h5555 : 32'h0);
        chk("rst_Rd2", Rd2, 32'h0);
        drive(0, 0, 0, 0, 0, 0, 0, '0, 0, 0);
        reset = 1'b0;
        drive(3, 0, 0, 0, 0, 0, 0, '0, 0, 0);
        cycle();  // x3 must still read 0

        // Write x5, then reset asynchronously between edges
        drive(0, 0, 9, 1, 0, 1, 5, 32'hDEAD, 0, 0);
        cycle();
        drive(5, 0, 9, 1, 0, 1, 6, 32'hBEEF, 0, 0);
        #2;
        chk("pre_rst_Rd1", Rd1, 32'hDEAD);
        reset = 1'b1;
        #1;
        chk("async_rst_Rd1", Rd1, 32'h0);
        check_lat('0, "async_rst");
        @(posedge clk); #1;
        drive(6, 5, 0, 0, 0, 0, 0, '0, 0, 0);
        #1;
        chk("rst_midwrite_x6", Rd1, 32'h0);
        chk("rst_x5", Rd2, 32'h0);
        reset = 1'b0;
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
        m_lat = '0;
        exp_q.delete();
        cycle();

        // x0 protection
        drive(0, 0, 0, 1, 0, 1, 0, 32'hFFFF_FFFF, 0, 0);
        #2; chk("x0_same", Rd1, 32'h0);
        cycle();
        drive(0, 0, 0, 1, 0, 0, 0, '0, 0, 0);
        #2; chk("x0_next", Rd1, 32'h0);
        cycle();

        // Bypass vs. pre-write read
        drive(7, 0, 0, 1, 0, 1, 7, 32'h1234, 0, 0);
        #2; chk("byp_same", Rd1, BYP ? 32'h1234 : 32'h0);
        cycle();
        chk("byp_Rd1E", Rd1E, BYP ? 32'h1234 : 32'h0);
        drive(7, 7, 0, 1, 0, 0, 0, '0, 0, 0);
        #2; chk("byp_next", Rd1, 32'h1234);
        cycle();

        // Stall holds the latch; writes continue; flush beats stall
        drive(0, 0, 0, 0, 0, 1, 2, 32'hA, 0, 0);
        cycle();
        drive(2, 0, 4, 1, 0, 0, 0, '0, 0, 0);
        cycle();
        chk("cap_Rd1E", Rd1E, 32'hA);
        for (int k = 0; k < 3; k++) begin
            drive(5'(7 - k), 5'(k), 5'(k + 10), 1, 1, 1, 5'(20 + k), 32'(k + 100), 1, 0);
            cycle();
            chk("stall_Rd1E", Rd1E, 32'hA);
        end
        drive(7, 0, 4, 1, 1, 0, 0, '0, 1, 1);
        cycle();
        chk("flush_ValidE", ValidE, 1'b0);
        chk("flush_Rd1E", Rd1E, 32'h0);
        drive(21, 22, 0, 0, 0, 0, 0, '0, 0, 0);
        cycle();
        chk("stall_write_x21", Rd1E, 32'd101);

        // Load-use hazard
        drive(0, 0, 3, 1, 1, 0, 0, '0, 0, 0);
        cycle();
        drive(1, 3, 8, 1, 0, 0, 0, '0, 1, 0);
        #2; chk("luh_set", LoadUseHazard, 1'b1);
        cycle();
        drive(1, 3, 8, 0, 0, 0, 0, '0, 1, 0);
        #2; chk("luh_validd0", LoadUseHazard, 1'b0);
        cycle();
        drive(0, 0, 0, 1, 1, 0, 0, '0, 0, 0);
        cycle();
        drive(0, 5, 8, 1, 0, 0, 0, '0, 0, 0);
        #2; chk("luh_rde0", LoadUseHazard, 1'b0);
        cycle();

        // Random traffic against the model
        for (int n = 0; n < 80; n++) begin
            drive(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                  1'($urandom), 1'($urandom), 1'($urandom),
                  5'($urandom_range(0, 31)), $urandom,
                  ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0));
            if ($urandom_range(0, 3) == 0) A3 = Rs1D;
            cycle();
        end

        // 64-bit instance: full-width write and read
        w_we = 1; w_a3 = 31; w_wd = 64'h8000_0000_0000_0001; w_rs2 = 31;
        #3;
        chk("x64_Rd2_same", w_rd2, BYP ? 64'h8000_0000_0000_0001 : 64'h0);
        @(posedge clk); #1;
        w_we = 0; w_wd = '0;
        #2;
        chk("x64_Rd2", w_rd2, 64'h8000_0000_0000_0001);
        @(posedge clk); #1;
        chk("x64_Rd2E", w_rd2e, 64'h8000_0000_0000_0001);
        chk("x64_Rs2E", w_rs2e, 5'd31);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
